// File: rtl/data_io_pkg.sv
// Shared constants and types for the data_io_loader download port.
package data_io_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] UIO_FILE_TX     = 8'h53;
  localparam logic [BYTE_W-1:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [BYTE_W-1:0] UIO_FILE_INDEX  = 8'h55;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/data_io_loader_if.sv
// Memory write channel: req/ack handshake with byte-addressed word and byte enables.
interface data_io_loader_if
  import data_io_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned BE_W = DATA_W / BYTE_W;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, output wr_be, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, input wr_be, output wr_ack);
endinterface

// File: rtl/data_io_loader_spi_byte_rx.sv
// SPI receiver oversampled in the clk domain: synchronisers, sck edge detect and byte framing.
module spi_byte_rx
  import data_io_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_sdi,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              is_cmd
);

  logic [1:0] sck_s;
  logic [1:0] ss_s;
  logic [1:0] sdi_s;
  logic       sck_d;
  logic [3:0] bit_cnt;
  logic [6:0] shift;
  logic       rise_c;

  assign rise_c = sck_s[1] & ~sck_d;

  // Two-flop synchronisers; ss resets to the deselected level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_s <= 2'b00;
      ss_s  <= 2'b11;
      sdi_s <= 2'b00;
      sck_d <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], spi_sck};
      ss_s  <= {ss_s[0], spi_ss};
      sdi_s <= {sdi_s[0], spi_sdi};
      sck_d <= sck_s[1];
    end
  end

  // Bits 0-7 are the command; bits 8-15 repeat for every following data byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= 4'd0;
      shift      <= 7'd0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      is_cmd     <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (ss_s[1]) begin
        bit_cnt <= 4'd0;
      end else if (rise_c) begin
        shift <= {shift[5:0], sdi_s[1]};
        if (bit_cnt[2:0] == 3'd7) begin
          rx_byte    <= {shift, sdi_s[1]};
          byte_valid <= 1'b1;
          is_cmd     <= ~bit_cnt[3];
        end
        bit_cnt <= (bit_cnt == 4'd15) ? 4'd8 : bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/data_io_loader.sv
// SPI file download port: decodes 0x53/0x54/0x55, packs bytes into DATA_W words for a req/ack memory port.
// Optional running XOR checksum on the cksum port when DATA_IO_CKSUM_EN is defined.
module data_io_loader
  import data_io_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DATA_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [7:0]        PAD        = 8'hFF
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_sdi,
  output logic              downloading,
  output logic [7:0]        index,
  output logic [ADDR_W:0]   size,
  output logic              overflow,
  data_io_loader_if.master  wr,
  output logic [7:0]        cksum
);

  localparam int unsigned LANES  = DATA_W / BYTE_W;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned SIZE_W = ADDR_W + 1;
  localparam logic [SIZE_W-1:0] SIZE_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [BYTE_W-1:0] rx_byte;
  logic              byte_valid;
  logic              is_cmd;

  state_t            state, state_nxt;
  logic              dl_nxt;
  logic [BYTE_W-1:0] cmd;
  logic [LANE_W-1:0] fill;
  logic [DATA_W-1:0] pack;
  logic [ADDR_W-1:0] wptr;

  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [LANES-1:0]  be_q;

  logic              data_c, start_c, stop_c, dat_c, index_c;
  logic              last_lane_c, slot_free_c, has_part_c, flush_c;
  logic [DATA_W-1:0] word_c, pad_c;
  logic [LANES-1:0]  be_c;

  spi_byte_rx u_rx (
    .clk        (clk),
    .reset      (reset),
    .spi_sck    (spi_sck),
    .spi_ss     (spi_ss),
    .spi_sdi    (spi_sdi),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .is_cmd     (is_cmd)
  );

  assign data_c      = byte_valid & ~is_cmd;
  assign start_c     = data_c && (cmd == UIO_FILE_TX) && rx_byte[0];
  assign stop_c      = data_c && (cmd == UIO_FILE_TX) && !rx_byte[0];
  assign dat_c       = data_c && (cmd == UIO_FILE_TX_DAT) && (state == LOAD);
  assign index_c     = data_c && (cmd == UIO_FILE_INDEX);
  assign last_lane_c = (fill == LANE_W'(LANES - 1));
  assign slot_free_c = !req_q || wr.wr_ack;
  assign has_part_c  = (fill != '0);
  assign flush_c     = (state == FLUSH) && has_part_c && slot_free_c;

  assign wr.wr_req  = req_q;
  assign wr.wr_addr = addr_q;
  assign wr.wr_data = data_q;
  assign wr.wr_be   = be_q;

  // Word with the incoming byte merged, and the padded partial word for a flush.
  always_comb begin
    word_c = pack;
    pad_c  = '0;
    be_c   = '0;
    word_c[int'(fill)*BYTE_W +: BYTE_W] = rx_byte;
    for (int i = 0; i < int'(LANES); i++) begin
      be_c[i] = (LANE_W'(i) < fill);
      pad_c[i*BYTE_W +: BYTE_W] = be_c[i] ? pack[i*BYTE_W +: BYTE_W] : PAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A start command restarts from any state; FLUSH ends once nothing is left to write.
  always_comb begin
    state_nxt = state;
    if (start_c) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (stop_c) state_nxt = FLUSH;
        FLUSH:   if (!has_part_c && slot_free_c) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    dl_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      downloading <= 1'b0;
      index       <= '0;
      size        <= '0;
      overflow    <= 1'b0;
      cmd         <= '0;
      req_q       <= 1'b0;
      addr_q      <= START_ADDR;
      data_q      <= '0;
      be_q        <= '0;
      wptr        <= START_ADDR;
      fill        <= '0;
      pack        <= '0;
    end else begin
      downloading <= dl_nxt;
      if (byte_valid && is_cmd) cmd <= rx_byte;
      if (index_c) index <= rx_byte;
      if (start_c) begin
        size     <= '0;
        overflow <= 1'b0;
        req_q    <= 1'b0;
        wptr     <= START_ADDR;
        fill     <= '0;
        pack     <= '0;
      end else begin
        if (req_q && wr.wr_ack) req_q <= 1'b0;
        if (dat_c) begin
          pack <= word_c;
          if (size != SIZE_MAX) size <= size + SIZE_W'(1);
          if (last_lane_c) begin
            // Pointer advances even for a dropped word so the memory layout is kept.
            fill <= '0;
            wptr <= wptr + ADDR_W'(LANES);
            if (slot_free_c) begin
              req_q  <= 1'b1;
              addr_q <= wptr;
              data_q <= word_c;
              be_q   <= '1;
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            fill <= fill + LANE_W'(1);
          end
        end else if (flush_c) begin
          req_q  <= 1'b1;
          addr_q <= wptr;
          data_q <= pad_c;
          be_q   <= be_c;
          fill   <= '0;
          wptr   <= wptr + ADDR_W'(LANES);
        end
      end
    end
  end

`ifdef DATA_IO_CKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cksum <= '0;
    else if (start_c) cksum <= '0;
    else if (dat_c)   cksum <= cksum ^ rx_byte;
  end
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_data_io_loader.sv
// Scoreboard bench for data_io_loader: one DATA_W=8 and one DATA_W=16 instance sharing the SPI lines.
module tb_data_io_loader;
  import data_io_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } exp_t;

  logic clk;
  logic reset;
  logic sck, ss, sdi, sel;
  logic ss8, ss16;
  logic hold8, hold16;

  logic        dl8, dl16, ov8, ov16;
  logic [7:0]  idx8, idx16, ck8, ck16;
  logic [16:0] sz8, sz16;

  int checks;
  int errors;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  data_io_loader_if #(.ADDR_W(16), .DATA_W(8))  w8 ();
  data_io_loader_if #(.ADDR_W(16), .DATA_W(16)) w16 ();

  assign ss8  = ss | sel;
  assign ss16 = ss | ~sel;

  data_io_loader #(.ADDR_W(16), .DATA_W(8), .START_ADDR(16'h0000), .PAD(8'hFF)) u_dut8 (
    .clk (clk), .reset (reset), .spi_sck (sck), .spi_ss (ss8), .spi_sdi (sdi),
    .downloading (dl8), .index (idx8), .size (sz8), .overflow (ov8), .wr (w8), .cksum (ck8)
  );

  data_io_loader #(.ADDR_W(16), .DATA_W(16), .START_ADDR(16'h0000), .PAD(8'hFF)) u_dut16 (
    .clk (clk), .reset (reset), .spi_sck (sck), .spi_ss (ss16), .spi_sdi (sdi),
    .downloading (dl16), .index (idx16), .size (sz16), .overflow (ov16), .wr (w16), .cksum (ck16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack one cycle after a request, checking each accepted write against the queue.
  always @(negedge clk) begin
    if (w8.wr_req === 1'b1 && w8.wr_ack !== 1'b1 && !hold8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL wr8_unexpected: got addr=%h data=%h be=%b, required no write", w8.wr_addr, w8.wr_data, w8.wr_be);
      end else begin
        e8 = q8.pop_front();
        if ({w8.wr_addr, 8'h00, w8.wr_data, 1'b0, w8.wr_be} !== {e8.addr, e8.data, e8.be}) begin
          errors++;
          $display("FAIL wr8_data: got addr=%h data=%h be=%b, required addr=%h data=%h be=%b",
                   w8.wr_addr, w8.wr_data, w8.wr_be, e8.addr, e8.data[7:0], e8.be[0]);
        end
      end
      w8.wr_ack = 1'b1;
    end else begin
      w8.wr_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (w16.wr_req === 1'b1 && w16.wr_ack !== 1'b1 && !hold16) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL wr16_unexpected: got addr=%h data=%h be=%b, required no write", w16.wr_addr, w16.wr_data, w16.wr_be);
      end else begin
        e16 = q16.pop_front();
        if ({w16.wr_addr, w16.wr_data, w16.wr_be} !== {e16.addr, e16.data, e16.be}) begin
          errors++;
          $display("FAIL wr16_data: got addr=%h data=%h be=%b, required addr=%h data=%h be=%b",
                   w16.wr_addr, w16.wr_data, w16.wr_be, e16.addr, e16.data, e16.be);
        end
      end
      w16.wr_ack = 1'b1;
    end else begin
      w16.wr_ack = 1'b0;
    end
  end

  task automatic spi_bit(input logic b);
    @(negedge clk);
    sdi = b;
    sck = 1'b0;
    repeat (2) @(negedge clk);
    sck = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) spi_bit(b[7-i]);
  endtask

  task automatic spi_begin();
    @(negedge clk);
    ss = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (4) @(negedge clk);
    sck = 1'b0;
    ss  = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] d);
    spi_begin();
    spi_bits(c, 8);
    spi_bits(d, 8);
    spi_end();
  endtask

  task automatic wait_idle(input bit d);
    int  n;
    bit  busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
      busy = d ? (dl16 || w16.wr_req) : (dl8 || w8.wr_req);
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle dut%0d: still busy after %0d cycles, required idle", d ? 16 : 8, n);
    end
  endtask

  function automatic logic [7:0] ck_exp(input logic [7:0] x);
`ifdef DATA_IO_CKSUM_EN
    return x;
`else
    return 8'h00 & x;
`endif
  endfunction

  task automatic test_reset();
    checks++;
    if ({dl8, idx8, sz8, ov8, ck8} !== '0) begin
      errors++;
      $display("FAIL reset_status8: got dl=%b idx=%h size=%h ovf=%b ck=%h, required all zero", dl8, idx8, sz8, ov8, ck8);
    end
    checks++;
    if ({w8.wr_req, w8.wr_addr, w8.wr_data, w8.wr_be} !== '0) begin
      errors++;
      $display("FAIL reset_bus8: got req=%b addr=%h data=%h be=%b, required all zero", w8.wr_req, w8.wr_addr, w8.wr_data, w8.wr_be);
    end
    checks++;
    if ({dl16, idx16, sz16, ov16, ck16} !== '0) begin
      errors++;
      $display("FAIL reset_status16: got dl=%b idx=%h size=%h ovf=%b ck=%h, required all zero", dl16, idx16, sz16, ov16, ck16);
    end
    checks++;
    if ({w16.wr_req, w16.wr_addr, w16.wr_data, w16.wr_be} !== '0) begin
      errors++;
      $display("FAIL reset_bus16: got req=%b addr=%h data=%h be=%b, required all zero", w16.wr_req, w16.wr_addr, w16.wr_data, w16.wr_be);
    end
  endtask

  task automatic test_basic8();
    logic [7:0] d[4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    logic [7:0] ck = 8'h00;
    sel = 1'b0;
    send_cmd(UIO_FILE_TX, 8'h01);
    checks++;
    if (dl8 !== 1'b1) begin
      errors++;
      $display("FAIL basic8_start: downloading=%b, required 1", dl8);
    end
    spi_begin();
    spi_bits(UIO_FILE_TX_DAT, 8);
    for (int i = 0; i < 4; i++) begin
      q8.push_back('{addr: 16'(i), data: {8'h00, d[i]}, be: 2'b01});
      ck ^= d[i];
      spi_bits(d[i], 8);
    end
    spi_end();
    send_cmd(UIO_FILE_TX, 8'h00);
    wait_idle(1'b0);
    checks++;
    if ({sz8, ov8, ck8, q8.size()} !== {17'd4, 1'b0, ck_exp(ck), 32'd0}) begin
      errors++;
      $display("FAIL basic8_end: got size=%0d ovf=%b ck=%h pending=%0d, required size=4 ovf=0 ck=%h pending=0",
               sz8, ov8, ck8, q8.size(), ck_exp(ck));
    end
  endtask

  task automatic test_partial16();
    sel = 1'b1;
    send_cmd(UIO_FILE_TX, 8'h01);
    q16.push_back('{addr: 16'h0000, data: 16'h2211, be: 2'b11});
    q16.push_back('{addr: 16'h0002, data: 16'hFF33, be: 2'b01});
    spi_begin();
    spi_bits(UIO_FILE_TX_DAT, 8);
    spi_bits(8'h11, 8);
    spi_bits(8'h22, 8);
    spi_bits(8'h33, 8);
    spi_end();
    send_cmd(UIO_FILE_TX, 8'h00);
    wait_idle(1'b1);
    checks++;
    if ({sz16, ov16, ck16, q16.size()} !== {17'd3, 1'b0, ck_exp(8'h11 ^ 8'h22 ^ 8'h33), 32'd0}) begin
      errors++;
      $display("FAIL partial16_end: got size=%0d ovf=%b ck=%h pending=%0d, required size=3 ovf=0 pending=0",
               sz16, ov16, ck16, q16.size());
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ck = 8'h00;
    sel = 1'b0;
    send_cmd(UIO_FILE_TX, 8'h01);
    hold8 = 1'b1;
    q8.push_back('{addr: 16'h0000, data: 16'h00B0, be: 2'b01});
    spi_begin();
    spi_bits(UIO_FILE_TX_DAT, 8);
    for (int i = 0; i < 4; i++) begin
      ck ^= 8'hB0 + 8'(i);
      spi_bits(8'hB0 + 8'(i), 8);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({ov8, w8.wr_req, w8.wr_addr} !== {1'b1, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL overflow_hold: got ovf=%b req=%b addr=%h, required ovf=1 req=1 addr=0000", ov8, w8.wr_req, w8.wr_addr);
    end
    hold8 = 1'b0;
    q8.push_back('{addr: 16'h0004, data: 16'h00B4, be: 2'b01});
    ck ^= 8'hB4;
    spi_bits(8'hB4, 8);
    spi_end();
    send_cmd(UIO_FILE_TX, 8'h00);
    wait_idle(1'b0);
    checks++;
    if ({sz8, ov8, ck8, q8.size()} !== {17'd5, 1'b1, ck_exp(ck), 32'd0}) begin
      errors++;
      $display("FAIL overflow_end: got size=%0d ovf=%b ck=%h pending=%0d, required size=5 ovf=1 ck=%h pending=0",
               sz8, ov8, ck8, q8.size(), ck_exp(ck));
    end
    send_cmd(UIO_FILE_TX, 8'h01);
    checks++;
    if ({dl8, ov8, sz8, ck8} !== {1'b1, 1'b0, 17'd0, 8'h00}) begin
      errors++;
      $display("FAIL overflow_restart: got dl=%b ovf=%b size=%0d ck=%h, required dl=1 ovf=0 size=0 ck=00", dl8, ov8, sz8, ck8);
    end
    send_cmd(UIO_FILE_TX, 8'h00);
    wait_idle(1'b0);
  endtask

  task automatic test_index();
    sel = 1'b1;
    send_cmd(UIO_FILE_TX, 8'h01);
    q16.push_back('{addr: 16'h0000, data: 16'h0201, be: 2'b11});
    q16.push_back('{addr: 16'h0002, data: 16'h0403, be: 2'b11});
    spi_begin();
    spi_bits(UIO_FILE_TX_DAT, 8);
    spi_bits(8'h01, 8);
    spi_bits(8'h02, 8);
    spi_end();
    send_cmd(UIO_FILE_INDEX, 8'h07);
    checks++;
    if ({idx16, dl16} !== {8'h07, 1'b1}) begin
      errors++;
      $display("FAIL index_mid: got idx=%h dl=%b, required idx=07 dl=1", idx16, dl16);
    end
    spi_begin();
    spi_bits(UIO_FILE_TX_DAT, 8);
    spi_bits(8'h03, 8);
    spi_bits(8'h04, 8);
    spi_end();
    send_cmd(UIO_FILE_TX, 8'h00);
    wait_idle(1'b1);
    checks++;
    if ({sz16, idx16, ck16, q16.size()} !== {17'd4, 8'h07, ck_exp(8'h04), 32'd0}) begin
      errors++;
      $display("FAIL index_end: got size=%0d idx=%h ck=%h pending=%0d, required size=4 idx=07 pending=0",
               sz16, idx16, ck16, q16.size());
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    send_cmd(UIO_FILE_TX, 8'h01);
    q8.push_back('{addr: 16'h0000, data: 16'h00C1, be: 2'b01});
    q8.push_back('{addr: 16'h0001, data: 16'h00C2, be: 2'b01});
    spi_begin();
    spi_bits(UIO_FILE_TX_DAT, 8);
    spi_bits(8'hC1, 8);
    spi_bits(8'hC2, 8);
    spi_bits(8'hC3, 4);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({dl8, sz8, ov8, ck8, w8.wr_req, w8.wr_addr, w8.wr_data, w8.wr_be} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got dl=%b size=%0d ovf=%b ck=%h req=%b addr=%h data=%h be=%b, required all zero",
               dl8, sz8, ov8, ck8, w8.wr_req, w8.wr_addr, w8.wr_data, w8.wr_be);
    end
    @(negedge clk);
    ss  = 1'b1;
    sck = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send_cmd(UIO_FILE_TX, 8'h01);
    q8.push_back('{addr: 16'h0000, data: 16'h00D1, be: 2'b01});
    q8.push_back('{addr: 16'h0001, data: 16'h00D2, be: 2'b01});
    spi_begin();
    spi_bits(UIO_FILE_TX_DAT, 8);
    spi_bits(8'hD1, 8);
    spi_bits(8'hD2, 8);
    spi_end();
    send_cmd(UIO_FILE_TX, 8'h00);
    wait_idle(1'b0);
    checks++;
    if ({sz8, q8.size()} !== {17'd2, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid_reload: got size=%0d pending=%0d, required size=2 pending=0", sz8, q8.size());
    end
  endtask

  task automatic test_abort_byte();
    sel = 1'b0;
    send_cmd(UIO_FILE_TX, 8'h01);
    spi_begin();
    spi_bits(UIO_FILE_TX_DAT, 8);
    spi_bits(8'hE5, 5);
    spi_end();
    repeat (4) @(negedge clk);
    checks++;
    if ({sz8, w8.wr_req} !== {17'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort_partial: got size=%0d req=%b, required size=0 req=0", sz8, w8.wr_req);
    end
    q8.push_back('{addr: 16'h0000, data: 16'h00E6, be: 2'b01});
    spi_begin();
    spi_bits(UIO_FILE_TX_DAT, 8);
    spi_bits(8'hE6, 8);
    spi_end();
    send_cmd(UIO_FILE_TX, 8'h00);
    wait_idle(1'b0);
    checks++;
    if ({sz8, ck8, q8.size()} !== {17'd1, ck_exp(8'hE6), 32'd0}) begin
      errors++;
      $display("FAIL abort_next: got size=%0d ck=%h pending=%0d, required size=1 pending=0", sz8, ck8, q8.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    sck    = 1'b0;
    ss     = 1'b1;
    sdi    = 1'b0;
    sel    = 1'b0;
    hold8  = 1'b0;
    hold16 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    test_reset();
    test_basic8();
    test_partial16();
    test_overflow();
    test_index();
    test_reset_mid();
    test_abort_byte();

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
